// File: rtl/mtr_drv_pkg.sv
// Shared types and constants for the two-channel H-bridge PWM driver.
package mtr_drv_pkg;

    localparam int PWM_PERIOD_BITS = 11;
    localparam int SPD_BITS        = 12;

    typedef logic [PWM_PERIOD_BITS-1:0] pwm_cnt_t;
    typedef logic signed [SPD_BITS-1:0] spd_t;
    typedef logic [5:0]                 dead_t;

    typedef struct packed {
        logic pwm1;
        logic pwm2;
    } bridge_drv_t;

    localparam pwm_cnt_t DUTY_OFFSET      = 11'd1024;
    localparam pwm_cnt_t CNT_MAX          = '1;
    localparam spd_t     SPD_CLIP_MAX     = 12'sd1023;
    localparam spd_t     SPD_CLIP_MIN     = -12'sd1024;
    localparam dead_t    DEAD_CYC_DEFAULT = 6'd32;

    // Clip to the 11-bit signed range, then offset so speed 0 lands at 50 % duty.
    function automatic pwm_cnt_t spd_to_duty(spd_t spd);
        spd_t clipped;
        if (spd > SPD_CLIP_MAX) begin
            clipped = SPD_CLIP_MAX;
        end else if (spd < SPD_CLIP_MIN) begin
            clipped = SPD_CLIP_MIN;
        end else begin
            clipped = spd;
        end
        return pwm_cnt_t'(clipped) + DUTY_OFFSET;
    endfunction

endpackage

// File: rtl/mtr_drv_if.sv
// Speed command / enable in, four bridge drives out.
interface mtr_drv_if;
    import mtr_drv_pkg::*;

    logic mtr_en;
    spd_t lft_spd;
    spd_t rght_spd;
    logic PWM1_lft;
    logic PWM2_lft;
    logic PWM1_rght;
    logic PWM2_rght;

    modport master (
        output mtr_en, lft_spd, rght_spd,
        input  PWM1_lft, PWM2_lft, PWM1_rght, PWM2_rght
    );

    modport slave (
        input  mtr_en, lft_spd, rght_spd,
        output PWM1_lft, PWM2_lft, PWM1_rght, PWM2_rght
    );

endinterface

// File: rtl/mtr_drv_pwm_deadtime.sv
// One H-bridge channel: duty shadow, raw compare against the shared counter,
// dead-time insertion and registered complementary drives.
module pwm_deadtime
    import mtr_drv_pkg::*;
#(
    parameter dead_t DEAD_CYC = DEAD_CYC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  spd_t        spd,
    input  pwm_cnt_t    cnt,
    input  logic        load,
    output bridge_drv_t drv
);

    pwm_cnt_t duty_shadow;
    logic     raw;
    logic     raw_prev;
    logic     en_q;
    dead_t    dead_cnt;
    dead_t    dead_nxt;
    logic     dead_done;

    // en_q forces a fresh dead interval on the first enabled clock after a
    // disable or reset, so re-enable behaves like a raw transition.
    always_comb begin
        raw       = (cnt < duty_shadow);
        dead_nxt  = dead_cnt;
        if (!en || !en_q || (raw != raw_prev)) begin
            dead_nxt = '0;
        end else if (dead_cnt < DEAD_CYC) begin
            dead_nxt = dead_cnt + 6'd1;
        end
        dead_done = (dead_nxt == DEAD_CYC);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            duty_shadow <= DUTY_OFFSET;
            raw_prev    <= 1'b0;
            en_q        <= 1'b0;
            dead_cnt    <= '0;
            drv         <= '0;
        end else begin
            if (load) begin
                duty_shadow <= spd_to_duty(spd);
            end
            raw_prev <= raw;
            en_q     <= en;
            dead_cnt <= dead_nxt;
            drv.pwm1 <= en & raw & dead_done;
            drv.pwm2 <= en & ~raw & dead_done;
        end
    end

endmodule

// File: rtl/mtr_drv.sv
// Two-channel motor PWM driver: shared 2048-clock period counter feeding
// independent left/right dead-time channels.
module mtr_drv
    import mtr_drv_pkg::*;
#(
    parameter dead_t DEAD_CYC = DEAD_CYC_DEFAULT
) (
    input logic       clk,
    input logic       rst,
    mtr_drv_if.slave  bus
);

    pwm_cnt_t    cnt;
    logic        load;
    bridge_drv_t drv_lft;
    bridge_drv_t drv_rght;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 11'd1;
        end
    end

    // Shadow duties refresh on the last count so each period uses one duty.
    assign load = (cnt == CNT_MAX);

    pwm_deadtime #(.DEAD_CYC(DEAD_CYC)) u_lft (
        .clk  (clk),
        .rst  (rst),
        .en   (bus.mtr_en),
        .spd  (bus.lft_spd),
        .cnt  (cnt),
        .load (load),
        .drv  (drv_lft)
    );

    pwm_deadtime #(.DEAD_CYC(DEAD_CYC)) u_rght (
        .clk  (clk),
        .rst  (rst),
        .en   (bus.mtr_en),
        .spd  (bus.rght_spd),
        .cnt  (cnt),
        .load (load),
        .drv  (drv_rght)
    );

    assign bus.PWM1_lft  = drv_lft.pwm1;
    assign bus.PWM2_lft  = drv_lft.pwm2;
    assign bus.PWM1_rght = drv_rght.pwm1;
    assign bus.PWM2_rght = drv_rght.pwm2;

endmodule

// File: doc/mtr_drv.md
MTR_DRV -- requirements
Module: mtr_drv

Interface
REQ-001 Parameter DEAD_CYC, default 6'd32: dead-time length in clocks; legal range 1..63.
REQ-002 clk  input  1  system clock; all state updates on its rising edge.
REQ-003 rst  input  1  asynchronous reset, active high.
REQ-004 mtr_en  input  1  motor enable; low forces all PWM outputs low.
REQ-005 lft_spd  input  12  signed left speed command from balance control.
REQ-006 rght_spd  input  12  signed right speed command from balance control.
REQ-007 PWM1_lft, PWM2_lft  output  1 each  left H-bridge high/low drive.
REQ-008 PWM1_rght, PWM2_rght  output  1 each  right H-bridge high/low drive.

Function
REQ-009 An 11-bit period counter cnt SHALL increment every clock and wrap 2047->0, giving a 2048-clock PWM period.
REQ-010 Each channel's duty SHALL be computed as: speed clipped to -1024..+1023, plus 1024, as an 11-bit unsigned value (speed 0 -> duty 1024, i.e. 50 %).
REQ-011 Each channel SHALL hold a shadow duty register that loads the computed duty only on the clock where cnt==2047; speed changes mid-period SHALL NOT affect the current period.
REQ-012 Raw PWM SHALL be high when cnt < shadow duty, else low; duty 0 gives a constant-low raw signal.
REQ-013 Each channel SHALL have a 6-bit dead counter that clears on any change of raw versus its previous-cycle value and otherwise increments, saturating at DEAD_CYC.
REQ-014 PWM1 = raw AND (dead counter==DEAD_CYC); PWM2 = NOT raw AND (dead counter==DEAD_CYC); PWM1 and PWM2 SHALL never be high in the same cycle.
REQ-015 After every raw transition, both outputs of that channel SHALL be low for exactly DEAD_CYC clocks.
REQ-016 If a raw pulse is shorter than DEAD_CYC, the corresponding output SHALL never assert for that pulse, and no glitch SHALL appear on either output.
REQ-017 All PWM outputs SHALL be registered; an output SHALL reflect the cnt value of the previous clock (1-cycle latency).
REQ-018 When mtr_en is low, all four outputs SHALL be low on the next clock and dead counters SHALL be held at 0.
REQ-019 On mtr_en rising, both outputs SHALL stay low for DEAD_CYC clocks before either asserts.
REQ-020 cnt and shadow loading SHALL continue while mtr_en is low.
REQ-021 If mtr_en falls on the same clock as a shadow load, the load SHALL still occur.
REQ-022 Left and right channels SHALL share cnt and be otherwise independent.

Reset
REQ-023 While rst is high: cnt=0, both shadow duties=1024, dead counters=0, previous-raw flags=0, all four outputs=0.
REQ-024 Reset SHALL take effect asynchronously and override any in-progress period or dead-time interval.
REQ-025 After rst deasserts, outputs SHALL remain low for at least DEAD_CYC clocks.

Structure
REQ-026 A shared package SHALL hold PWM_PERIOD_BITS=11, DUTY_OFFSET=11'd1024, SPD_CLIP_MAX=+1023, SPD_CLIP_MIN=-1024, and DEAD_CYC_DEFAULT=6'd32.
REQ-027 One sub-module, pwm_deadtime, SHALL implement one channel: clip, offset, shadow register, raw compare, dead counter and output registers. mtr_drv SHALL instantiate it twice beside the shared counter.

Verification
REQ-028 lft_spd=0, mtr_en=1 -> PWM1_lft high for 1024-32=992 clocks per 2048-clock period, PWM2_lft high for 992 clocks, 32-clock both-low gaps at each edge.
REQ-029 rght_spd=+1500 -> clipped to 1023, duty 2047; the 1-clock low raw pulse yields PWM2_rght never high and PWM1_rght high for 2047-32=2015 clocks per period.
REQ-030 lft_spd changed from 0 to -512 at cnt=500 -> current period keeps duty 1024; the next period uses duty 512.
REQ-031 mtr_en dropped mid-high-phase -> all outputs 0 next clock. On re-enable, 32 clocks all-low before first assertion.
REQ-032 rst pulsed at cnt=1200 with PWM1 high -> outputs 0 immediately; cnt restarts at 0 with duty 1024 after release.
REQ-033 Random speeds for 10^5 clocks -> assertion that PWM1 & PWM2 is never 1 on either channel.
